// File: rtl/pcs25g_tb_pkg.sv
// Shared constants for the PCS25G bench receive checker: lane geometry, stamp layout, reset values.
// Also provides the resync helper that predicts the next word's base from lane 3.
package pcs25g_tb_pkg;

  localparam int LANES       = 16;
  localparam int LANE_W      = 12;
  localparam int TS_W        = 32;
  localparam int DATA_W      = LANES * LANE_W;
  localparam int STAMP_LANES = 3;
  localparam int RESYNC_LANE = 3;
  localparam int WINDOW_DEF  = 40000;

  localparam logic [3:0]  STAMP_PAD   = 4'b0000;
  localparam logic [31:0] LAT_MIN_RST = 32'hFFFF_FFFF;

  // Lane 3 carries base+3, so the following word's base is lane3 - 3 + LANES.
  function automatic logic [LANE_W-1:0] next_base(input logic [DATA_W-1:0] d);
    return d[RESYNC_LANE*LANE_W +: LANE_W] + LANE_W'(LANES - RESYNC_LANE);
  endfunction

endpackage

// File: rtl/chk192_rcvtime_if.sv
// Receive-side bundle for the 192-bit checker: word/stamp inputs and all measurement outputs.
// master drives the word stream, slave is the checker.
interface chk192_rcvtime_if;
  import pcs25g_tb_pkg::*;

  logic              in_rxen;
  logic [DATA_W-1:0] data;
  logic              rcvtime;
  logic [31:0]       time_now;
  logic              err;
  logic [LANES-1:0]  err_lane;
  logic [15:0]       err_cnt;
  logic [31:0]       word_cnt;
  logic [31:0]       lat;
  logic              lat_valid;
  logic [31:0]       lat_min;
  logic [31:0]       lat_max;
  logic [31:0]       bw_words;
  logic              bw_valid;

  modport master (
    output in_rxen, data, rcvtime, time_now,
    input  err, err_lane, err_cnt, word_cnt, lat, lat_valid,
           lat_min, lat_max, bw_words, bw_valid
  );

  modport slave (
    input  in_rxen, data, rcvtime, time_now,
    output err, err_lane, err_cnt, word_cnt, lat, lat_valid,
           lat_min, lat_max, bw_words, bw_valid
  );

endinterface

// File: rtl/chk192_lane_cmp.sv
// Combinational per-lane continuity compare: lane k must equal exp+k mod 2^LANE_W.
// Stamp lanes are excluded while rcvtime is set.
module chk192_lane_cmp
  import pcs25g_tb_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [LANE_W-1:0] exp_i,
  input  logic              rcvtime_i,
  output logic [LANES-1:0]  err_lane_o
);

  always_comb begin
    err_lane_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!(rcvtime_i && (k < STAMP_LANES))) begin
        err_lane_o[k] = data_i[k*LANE_W +: LANE_W] != (exp_i + LANE_W'(k));
      end
    end
  end

endmodule

// File: rtl/chk192_rcvtime.sv
// Receive checker for the 192-bit incrementing pattern: continuity, stamp latency, bandwidth.
// All outputs registered, one clk after the word; resyncs from lane 3 on every word.
module chk192_rcvtime
  import pcs25g_tb_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF
)(
  input  logic             clk,
  input  logic             reset_n,
  chk192_rcvtime_if.slave  bus
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [LANE_W-1:0] exp_q;
  logic              synced_q;
  logic              err_q;
  logic [LANES-1:0]  err_lane_q;
  logic [15:0]       err_cnt_q;
  logic [31:0]       word_cnt_q;
  logic [31:0]       lat_q;
  logic              lat_valid_q;
  logic [31:0]       lat_min_q;
  logic [31:0]       lat_max_q;
  logic [WIN_W-1:0]  win_q;
  logic [31:0]       win_words_q;
  logic [31:0]       bw_words_q;
  logic              bw_valid_q;

  logic [LANES-1:0]  cmp_lane;
  logic              stamp_bad;
  logic              lat_ok;
  logic [LANES-1:0]  err_lane_d;
  logic [31:0]       lat_d;
  logic [31:0]       rx_inc;

  chk192_lane_cmp u_lane_cmp (
    .data_i     (bus.data),
    .exp_i      (exp_q),
    .rcvtime_i  (bus.rcvtime),
    .err_lane_o (cmp_lane)
  );

  assign stamp_bad = bus.rcvtime && (bus.data[35:TS_W] != STAMP_PAD);
  assign lat_ok    = bus.rcvtime && !stamp_bad;
  assign lat_d     = bus.time_now - bus.data[TS_W-1:0];
  assign rx_inc    = {31'd0, bus.in_rxen};

  // The resync word after reset is never flagged, not even for a malformed stamp.
  always_comb begin
    err_lane_d = '0;
    if (synced_q) begin
      err_lane_d = cmp_lane;
      if (stamp_bad) begin
        err_lane_d[STAMP_LANES-1:0] = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q       <= '0;
      synced_q    <= 1'b0;
      err_q       <= 1'b0;
      err_lane_q  <= '0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      lat_q       <= '0;
      lat_valid_q <= 1'b0;
      lat_min_q   <= LAT_MIN_RST;
      lat_max_q   <= '0;
    end else begin
      err_q       <= 1'b0;
      lat_valid_q <= 1'b0;
      if (bus.in_rxen) begin
        synced_q   <= 1'b1;
        exp_q      <= next_base(bus.data);
        word_cnt_q <= word_cnt_q + 32'd1;
        err_lane_q <= err_lane_d;
        err_q      <= |err_lane_d;
        if ((|err_lane_d) && (err_cnt_q != 16'hFFFF)) begin
          err_cnt_q <= err_cnt_q + 16'd1;
        end
        if (lat_ok) begin
          lat_q       <= lat_d;
          lat_valid_q <= 1'b1;
          if (lat_d < lat_min_q) lat_min_q <= lat_d;
          if (lat_d > lat_max_q) lat_max_q <= lat_d;
        end
      end
    end
  end

  // The window runs on every clock; the word arriving on the wrap cycle belongs to the closing window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q       <= '0;
      win_words_q <= '0;
      bw_words_q  <= '0;
      bw_valid_q  <= 1'b0;
    end else begin
      bw_valid_q <= 1'b0;
      if (win_q == WIN_W'(WINDOW - 1)) begin
        win_q       <= '0;
        win_words_q <= '0;
        bw_words_q  <= win_words_q + rx_inc;
        bw_valid_q  <= 1'b1;
      end else begin
        win_q       <= win_q + WIN_W'(1);
        win_words_q <= win_words_q + rx_inc;
      end
    end
  end

  assign bus.err       = err_q;
  assign bus.err_lane  = err_lane_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.lat       = lat_q;
  assign bus.lat_valid = lat_valid_q;
  assign bus.lat_min   = lat_min_q;
  assign bus.lat_max   = lat_max_q;
  assign bus.bw_words  = bw_words_q;
  assign bus.bw_valid  = bw_valid_q;

endmodule

// File: tb/tb_chk192_rcvtime.sv
// Scoreboard bench for chk192_rcvtime: a word-level reference model queues expected results,
// and a monitor compares them against the outputs one clock after each accepted word.
module tb_chk192_rcvtime;
  import pcs25g_tb_pkg::*;

  localparam int W = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  chk192_rcvtime_if ifc ();

  chk192_rcvtime #(.WINDOW(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    logic        err;
    logic [15:0] lane;
    logic        lv;
    logic [31:0] lat;
    logic [15:0] ecnt;
    logic [31:0] wcnt;
    logic [31:0] lmin;
    logic [31:0] lmax;
  } exp_t;

  exp_t        wq[$];
  int unsigned bwq[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // reference model state
  bit          m_sync;
  int          m_exp;
  int unsigned m_ecnt;
  int unsigned m_wcnt;
  logic [31:0] m_min;
  logic [31:0] m_max;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 1'b0;
    m_exp  = 0;
    m_ecnt = 0;
    m_wcnt = 0;
    m_min  = 32'hFFFF_FFFF;
    m_max  = 32'h0;
    wq.delete();
    bwq.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.in_rxen = 1'b0;
    end
  endtask

  // Build one pattern word, predict its result from the lane rules, and present it for one clock.
  task automatic send(input int base, input bit rcv, input logic [3:0] hi, input logic [31:0] stamp,
                      input logic [31:0] now, input logic [15:0] corrupt);
    logic [191:0] d;
    logic [15:0]  mask;
    logic [11:0]  want;
    logic [11:0]  got;
    logic [31:0]  lat;
    exp_t         e;
    @(negedge clk);
    d = '0;
    for (int k = 0; k < 16; k++) begin
      want = 12'((base + k) % 4096);
      if (corrupt[k]) want = (want == 12'd0) ? 12'd1 : 12'd0;
      d[12*k +: 12] = want;
    end
    if (rcv) d[35:0] = {hi, stamp};
    mask = '0;
    for (int k = 0; k < 16; k++) begin
      got  = d[12*k +: 12];
      want = 12'((m_exp + k) % 4096);
      if (!(rcv && k < 3) && got != want) mask[k] = 1'b1;
    end
    if (rcv && hi != 4'h0) mask[2:0] = 3'b111;
    if (!m_sync) mask = '0;
    m_wcnt++;
    if (mask != 0 && m_ecnt < 65535) m_ecnt++;
    e.err  = (mask != 0);
    e.lane = mask;
    e.lv   = rcv && (hi == 4'h0);
    e.lat  = now - stamp;
    if (e.lv) begin
      lat = now - stamp;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
    end
    e.ecnt = 16'(m_ecnt);
    e.wcnt = m_wcnt;
    e.lmin = m_min;
    e.lmax = m_max;
    m_exp  = (int'(d[47:36]) + 13) % 4096;
    m_sync = 1'b1;
    wq.push_back(e);
    ifc.in_rxen  = 1'b1;
    ifc.data     = d;
    ifc.rcvtime  = rcv;
    ifc.time_now = now;
  endtask

  // Optionally a word is left on the bus as reset hits it; that word must vanish.
  task automatic do_reset(input bit midword);
    @(negedge clk);
    ifc.in_rxen = midword;
    if (midword) ifc.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1 reset_n = 1'b0;
    model_reset();
    ifc.in_rxen = 1'b0;
    #2;
    chk("rst_err", ifc.err, 0);
    chk("rst_err_lane", ifc.err_lane, 0);
    chk("rst_err_cnt", ifc.err_cnt, 0);
    chk("rst_word_cnt", ifc.word_cnt, 0);
    chk("rst_lat", ifc.lat, 0);
    chk("rst_lat_valid", ifc.lat_valid, 0);
    chk("rst_lat_min", ifc.lat_min, 32'hFFFF_FFFF);
    chk("rst_lat_max", ifc.lat_max, 0);
    chk("rst_bw_words", ifc.bw_words, 0);
    chk("rst_bw_valid", ifc.bw_valid, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Monitor: a word seen at a rising edge must produce its result by the next falling edge.
  bit rx_seen;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_seen <= 1'b0;
    else          rx_seen <= ifc.in_rxen;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (rx_seen) begin
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: output for a word with no expectation at %0t", $time);
        end else begin
          e = wq.pop_front();
          chk("err", ifc.err, e.err);
          chk("err_lane", ifc.err_lane, e.lane);
          chk("lat_valid", ifc.lat_valid, e.lv);
          if (e.lv) chk("lat", ifc.lat, e.lat);
          chk("err_cnt", ifc.err_cnt, e.ecnt);
          chk("word_cnt", ifc.word_cnt, e.wcnt);
          chk("lat_min", ifc.lat_min, e.lmin);
          chk("lat_max", ifc.lat_max, e.lmax);
        end
      end else begin
        chk("idle_err", ifc.err, 0);
        chk("idle_lat_valid", ifc.lat_valid, 0);
      end
      if (ifc.bw_valid) begin
        if (bwq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bw_spurious: bw_valid with no window closing at %0t", $time);
        end else begin
          chk("bw_words", ifc.bw_words, bwq.pop_front());
        end
      end
    end
  end

  // Bandwidth reference: each window of W edges after reset yields its word count.
  int unsigned ref_edges;
  int unsigned ref_words;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_edges = 0;
      ref_words = 0;
    end else begin
      if (ifc.in_rxen) ref_words++;
      ref_edges++;
      if (ref_edges == W) begin
        bwq.push_back(ref_words);
        ref_edges = 0;
        ref_words = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit rcv;
    logic [31:0] stamp;
    logic [3:0] hi;
    logic [15:0] cor;
    ifc.in_rxen  = 1'b0;
    ifc.data     = '0;
    ifc.rcvtime  = 1'b0;
    ifc.time_now = '0;
    model_reset();
    do_reset(1'b0);

    send(0, 0, 4'h0, 0, 0, 16'h0);
    send(16, 0, 4'h0, 0, 0, 16'h0);
    send(32, 0, 4'h0, 0, 0, 16'h0);
    send(48, 0, 4'h0, 0, 0, 16'h0);
    send(96, 0, 4'h0, 0, 0, 16'h0);
    send(112, 0, 4'h0, 0, 0, 16'h0);
    send(128, 0, 4'h0, 0, 0, 16'h0080);
    send(144, 0, 4'h0, 0, 0, 16'h0);
    idle(1);

    send(160, 1, 4'h0, 32'd1000, 32'd1250, 16'h0);
    send(176, 1, 4'h0, 32'd2000, 32'd2100, 16'h0);
    send(192, 1, 4'h3, 32'd5, 32'd9, 16'h0);
    send(208, 1, 4'h0, 32'hFFFF_FFF0, 32'h0000_0010, 16'h0);
    idle(1);

    send(4074, 0, 4'h0, 0, 0, 16'h0);
    send(4090, 0, 4'h0, 0, 0, 16'h0);
    send(10, 0, 4'h0, 0, 0, 16'h0);
    idle(2);

    do_reset(1'b0);
    base = 0;
    for (int i = 0; i < 2 * W + 40; i++) begin
      if (i % 2 == 0) begin
        send(base, 0, 4'h0, 0, 0, 16'h0);
        base += 16;
      end else begin
        idle(1);
      end
    end
    do_reset(1'b1);
    base = 3000;
    for (int i = 0; i < 2 * W + 5; i++) begin
      if (i % 2 == 0) begin
        send(base, 0, 4'h0, 0, 0, 16'h0);
        base += 16;
      end else begin
        idle(1);
      end
    end

    rcv = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1: idle(1);
        2: begin
          idle(1);
          rcv = ~rcv;
        end
        default: begin
          if ($urandom_range(0, 9) == 0) base = int'($urandom_range(0, 4095));
          cor = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
          hi = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
          stamp = $urandom;
          send(base, rcv, hi, stamp, stamp + 32'($urandom_range(0, 100000)), cor);
          base = (base + 16) % 4096;
        end
      endcase
    end
    idle(4);
    chk("sb_drain", wq.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
